// File: rtl/fib_pkg.sv
// Shared types for the fib accelerator result path: word type and the
// serializer state encoding.
package fib_pkg;

  localparam int FIB_W = 32;

  typedef logic [FIB_W-1:0] fib_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count. A push while full
// or a pop while empty is ignored; written data is readable the next cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and level alone define
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: every sequential assignment uses <= so all registers update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fib_result_serializer.sv
// Buffers fib accelerator results and streams each word out as bytes,
// least significant byte first, over an 8-bit valid/ready link.
module fib_result_serializer
  import fib_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = FIB_W
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   vld_in,
  input  logic [DATA_W-1:0]      fib_in,
  output logic                   rdy_in,
  output logic [7:0]             byte_out,
  output logic                   byte_vld,
  input  logic                   byte_rdy,
  output logic                   byte_last,
  output logic [$clog2(DEPTH):0] level
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  ser_state_t        state;
  ser_state_t        state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              load;
  logic              shift;

  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  assign rdy_in    = !rst && !fifo_full;
  assign fifo_push = vld_in && rdy_in;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fib_in),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every signal driven here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (byte_rdy) begin
          if (idx == LAST_IDX) begin
            // Reload straight from the FIFO so consecutive words leave no gap.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              load     = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        shreg <= fifo_dout;
        idx   <= '0;
      end else if (shift) begin
        shreg <= shreg >> 8;
        idx   <= idx + IDX_W'(1);
      end
    end
  end

  // Outputs depend only on registered state, so they hold while stalled.
  assign byte_vld  = (state == SEND);
  assign byte_out  = byte_vld ? shreg[7:0] : 8'h00;
  assign byte_last = byte_vld && (idx == LAST_IDX);

endmodule

// File: tb/tb_fib_result_serializer.sv
// Self-checking bench for fib_result_serializer: directed scenarios plus a
// byte-queue reference model fed from observed input handshakes.
module tb_fib_result_serializer;
  import fib_pkg::*;

  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            rst;
  logic            vld_in;
  fib_word_t       fib_in;
  logic            rdy_in;
  logic [7:0]      byte_out;
  logic            byte_vld;
  logic            byte_rdy;
  logic            byte_last;
  logic [2:0]      level;

  int errors = 0;
  int checks = 0;
  int byte_cnt = 0;

  logic [7:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_byte;
  logic       stall_last;

  fib_result_serializer #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .vld_in    (vld_in),
    .fib_in    (fib_in),
    .rdy_in    (rdy_in),
    .byte_out  (byte_out),
    .byte_vld  (byte_vld),
    .byte_rdy  (byte_rdy),
    .byte_last (byte_last),
    .level     (level)
  );

  always #5 CLK = ~CLK;

  // One clock cycle: sample handshakes at the negedge (inputs are stable
  // then), update the model, then advance past the posedge.
  task automatic tick(output bit pushed);
    logic [7:0] exp_b;
    logic       exp_last;
    pushed = 1'b0;
    @(negedge CLK);
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (byte_vld !== 1'b1 || byte_out !== stall_byte || byte_last !== stall_last) begin
          errors++;
          $display("FAIL stall_hold: vld=%b byte=%h last=%b, required vld=1 byte=%h last=%b",
                   byte_vld, byte_out, byte_last, stall_byte, stall_last);
        end
      end
      if (byte_vld && byte_rdy) begin
        checks++;
        byte_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h, required no byte", byte_out);
        end else begin
          exp_b    = exp_q.pop_front();
          exp_last = (exp_q.size() % 4 == 0);
          if (byte_out !== exp_b || byte_last !== exp_last) begin
            errors++;
            $display("FAIL byte_stream: got byte=%h last=%b, required byte=%h last=%b",
                     byte_out, byte_last, exp_b, exp_last);
          end
        end
      end
      stall_prev = byte_vld && !byte_rdy;
      stall_byte = byte_out;
      stall_last = byte_last;
      if (vld_in && rdy_in) begin
        pushed = 1'b1;
        for (int b = 0; b < 4; b++) exp_q.push_back(fib_in[8*b +: 8]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    bit p;
    tick(p);
  endtask

  task automatic drain(input int max_cycles, input bit rand_rdy);
    int n = 0;
    while ((exp_q.size() != 0 || byte_vld) && n < max_cycles) begin
      if (rand_rdy) byte_rdy = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || byte_vld !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes pending, byte_vld=%b, required 0 and 0",
               exp_q.size(), byte_vld);
    end
    byte_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld_in = 1'b1; fib_in = 32'hDEADBEEF; byte_rdy = 1'b1;
    step();
    step();
    checks++;
    if (byte_vld !== 1'b0 || byte_last !== 1'b0 || byte_out !== 8'h00 ||
        level !== 3'd0 || rdy_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: vld=%b last=%b byte=%h level=%0d rdy_in=%b, required 0 0 00 0 0",
               byte_vld, byte_last, byte_out, level, rdy_in);
    end
    vld_in = 1'b0;
    rst    = 1'b0;
    #1;
    checks++;
    if (rdy_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: rdy_in=%b, required 1", rdy_in);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_b[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    byte_rdy = 1'b1; vld_in = 1'b1; fib_in = 32'h12345678;
    step();
    vld_in = 1'b0;
    checks++;
    if (byte_vld !== 1'b0 || level !== 3'd1) begin
      errors++;
      $display("FAIL single_latency: vld=%b level=%0d one cycle after push, required 0 1",
               byte_vld, level);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (byte_vld !== 1'b1 || byte_out !== exp_b[k] || byte_last !== (k == 3)) begin
        errors++;
        $display("FAIL single_byte%0d: vld=%b byte=%h last=%b, required 1 %h %b",
                 k, byte_vld, byte_out, byte_last, exp_b[k], (k == 3));
      end
      step();
    end
    checks++;
    if (byte_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: byte_vld=%b, required 0", byte_vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[8] = '{8'hE9, 8'h00, 8'h00, 8'h00, 8'h79, 8'h01, 8'h00, 8'h00};
    byte_rdy = 1'b1; vld_in = 1'b1; fib_in = 32'h000000E9;
    step();
    fib_in = 32'h00000179;
    step();
    vld_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (byte_vld !== 1'b1 || byte_out !== exp_b[k] || byte_last !== (k % 4 == 3)) begin
        errors++;
        $display("FAIL b2b_byte%0d: vld=%b byte=%h last=%b, required 1 %h %b",
                 k, byte_vld, byte_out, byte_last, exp_b[k], (k % 4 == 3));
      end
      step();
    end
    checks++;
    if (byte_vld !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: byte_vld=%b, required 0", byte_vld);
    end
  endtask

  task automatic test_full_backpressure();
    fib_word_t w[6];
    int idx = 0;
    int start;
    bit p;
    for (int i = 0; i < 6; i++) w[i] = {8'(i + 1), 24'($urandom)};
    start = byte_cnt;
    byte_rdy = 1'b0; vld_in = 1'b1; fib_in = w[0];
    for (int c = 0; c < 10; c++) begin
      tick(p);
      if (p) begin
        idx++;
        if (idx < 6) fib_in = w[idx];
      end
    end
    checks++;
    if (idx != 5 || rdy_in !== 1'b0 || level !== 3'd4) begin
      errors++;
      $display("FAIL full_accept: accepted=%0d rdy_in=%b level=%0d, required 5 0 4",
               idx, rdy_in, level);
    end
    byte_rdy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c >= 3) begin
        checks++;
        if (rdy_in !== (c == 4)) begin
          errors++;
          $display("FAIL full_rdy_reassert: rdy_in=%b after %0d bytes, required %b",
                   rdy_in, c, (c == 4));
        end
      end
    end
    tick(p);
    vld_in = 1'b0;
    checks++;
    if (!p) begin
      errors++;
      $display("FAIL full_sixth_push: accepted=%b, required 1", p);
    end
    drain(80, 1'b0);
    checks++;
    if (byte_cnt - start != 24 || level !== 3'd0) begin
      errors++;
      $display("FAIL full_byte_count: bytes=%0d level=%0d, required 24 0",
               byte_cnt - start, level);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int n = 0;
    int start;
    bit p;
    start = byte_cnt;
    while (idx < 3 && n < 100) begin
      byte_rdy = 1'($urandom_range(0, 1));
      vld_in   = 1'b1;
      fib_in   = $urandom;
      tick(p);
      if (p) idx++;
      n++;
    end
    vld_in = 1'b0;
    drain(300, 1'b1);
    checks++;
    if (idx != 3 || byte_cnt - start != 12) begin
      errors++;
      $display("FAIL stall_totals: words=%0d bytes=%0d, required 3 12", idx, byte_cnt - start);
    end
  endtask

  task automatic test_simultaneous();
    fib_word_t w[4];
    int start;
    bit p;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    start = byte_cnt;
    byte_rdy = 1'b0; vld_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fib_in = w[i];
      step();
    end
    vld_in = 1'b0;
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL simul_setup_level: level=%0d, required 2", level);
    end
    byte_rdy = 1'b1;
    repeat (3) step();
    checks++;
    if (byte_last !== 1'b1 || level !== 3'd2) begin
      errors++;
      $display("FAIL simul_pre: last=%b level=%0d, required 1 2", byte_last, level);
    end
    vld_in = 1'b1; fib_in = w[3];
    tick(p);
    vld_in = 1'b0;
    checks++;
    if (!p || level !== 3'd2 || byte_vld !== 1'b1 || byte_out !== w[1][7:0]) begin
      errors++;
      $display("FAIL simul_pushpop: pushed=%b level=%0d vld=%b byte=%h, required 1 2 1 %h",
               p, level, byte_vld, byte_out, w[1][7:0]);
    end
    drain(60, 1'b0);
    checks++;
    if (byte_cnt - start != 16) begin
      errors++;
      $display("FAIL simul_byte_count: bytes=%0d, required 16", byte_cnt - start);
    end
  endtask

  task automatic test_reset_mid();
    int start;
    byte_rdy = 1'b0; vld_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fib_in = $urandom;
      step();
    end
    vld_in = 1'b0;
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_setup_level: level=%0d, required 3", level);
    end
    byte_rdy = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    checks++;
    if (byte_vld !== 1'b0 || level !== 3'd0 || rdy_in !== 1'b0 || byte_out !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_state: vld=%b level=%0d rdy_in=%b byte=%h, required 0 0 0 00",
               byte_vld, level, rdy_in, byte_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_in !== 1'b1 || byte_vld !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: rdy_in=%b vld=%b, required 1 0", rdy_in, byte_vld);
    end
    start = byte_cnt;
    vld_in = 1'b1; fib_in = 32'hA5C3_0F81;
    step();
    vld_in = 1'b0;
    drain(20, 1'b0);
    checks++;
    if (byte_cnt - start != 4) begin
      errors++;
      $display("FAIL rstmid_new_word: bytes=%0d, required 4", byte_cnt - start);
    end
  endtask

  initial begin
    rst = 1'b1; vld_in = 1'b0; fib_in = '0; byte_rdy = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_backpressure();
    test_stall();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
